reggp_sb: RTL
=============

Name: reggp_sb

Overview:
- Parametrised general-purpose register file; successor to the single-write, two-read GP file.
- Configurable read-port count and two write ports (ALU writeback, load writeback).
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register scoreboard of pending writes, so the decode stage can stall on RAW hazards in the pipelined core.

Parameters:
- DATA_W, 24: register width in bits.
- ADDR_W, 4: register address width.
- NUM_REGS, 16: register count; must be no greater than 2^ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- BYPASS, 1: when 1, a same-cycle write is forwarded to a matching read port.
- ZERO_R0, 0: when 1, r0 reads 0, ignores writes and is never pending.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  asynchronous active-high reset.
- iw_read_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- ow_read_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- ow_read_ready  out  NUM_RD  port k data valid: its register is not pending, or the pending write is being bypassed this cycle.
- iw_wa_enable  in  1  write port A (ALU) enable.
- iw_wa_addr  in  ADDR_W  write port A address.
- iw_wa_data  in  DATA_W  write port A data.
- iw_wb_enable  in  1  write port B (load) enable.
- iw_wb_addr  in  ADDR_W  write port B address.
- iw_wb_data  in  DATA_W  write port B data.
- iw_issue_enable  in  1  an instruction issued that will write iw_issue_addr.
- iw_issue_addr  in  ADDR_W  destination of the issued instruction.
- ow_pending  out  NUM_REGS  scoreboard bits, bit i = register i has an outstanding write.

Behaviour:
- Reset (asynchronous, iw_rst=1):
  - all registers and all scoreboard bits go to 0 immediately;
  - ow_pending=0, ow_read_ready all 1, ow_read_data reads 0.
  - Reset asserted mid-operation discards any in-flight writes and issues; nothing is committed on the edge where reset is high.
- Writes commit on the rising edge.
  - If both ports are enabled with the same address, port B wins and port A's data is dropped.
  - Different addresses commit together.
  - Addresses at or above NUM_REGS are ignored.
- Reads are combinational from the register array.
  - BYPASS=1: read data equals the enabled write data of the same cycle for a matching address, port B taking priority over A. Otherwise it is the stored value.
  - BYPASS=0: a read returns the stored (pre-edge) value; the written value is visible the cycle after the write.
  - Out-of-range read address returns 0 with ready=1.
- Scoreboard, evaluated on each rising edge, per register i:
  - set if an issue targets i;
  - else clear if any write targets i;
  - else hold.
  - Issue and write to the same register in the same cycle leaves the bit set: the new producer is still outstanding.
  - Issue to an already-pending register keeps the bit set, with no counting; decode serialises WAW hazards.
  - A write to a non-pending register still commits, and the bit stays 0.
- ow_read_ready[k]:
  - 1 if pending[addr_k] is 0;
  - else 1 only if BYPASS=1 and an enabled write hits addr_k this cycle;
  - else 0.
- ZERO_R0=1:
  - writes and issues to r0 are ignored;
  - r0 reads 0, ready=1, and pending bit 0 is always 0;
  - bypass never applies to r0.
- Latency: write-to-read is 0 cycles with bypass and 1 cycle without; issue-to-pending is 1 cycle.
- No internal state besides the register array and the scoreboard.

Test Plan:
- Reset, then read all 16 registers: data 0, ready 1, ow_pending=0. Write r3=0x123456, then assert iw_rst between edges: r3 reads 0 immediately.
- Ports A and B both write r5 (A=0x000011, B=0x000022) in one cycle: r5=0x000022. Next, A writes r6=0xAAAAAA and B writes r7=0xBBBBBB together: both committed.
- BYPASS=1, A writes r2=0x0F0F0F while port 1 reads r2: same-cycle data is 0x0F0F0F. With BYPASS=0 the read returns the old value, then 0x0F0F0F the next cycle.
- Issue r4: next cycle pending[4]=1 and a read of r4 has ready=0. B writes r4=0x000099: with bypass, ready=1 and data 0x000099 that cycle; next cycle pending[4]=0.
- Issue r8 and A writes r8 in the same cycle: pending[8]=1 afterwards. A later write to r8 clears it.
- ZERO_R0=1: issue r0 and write r0=0xFFFFFF, then read r0: data 0, ready 1, pending[0]=0.

Source files
------------

// File: rtl/reggp_sb.sv
// reggp_sb: parametrised general-purpose register file with a pending-write scoreboard.
//
// Two write ports:
//   - A: ALU writeback.
//   - B: load writeback. B wins when both ports hit the same register.
//
// NUM_RD combinational read ports, each with a ready flag that tells decode
// whether the value it sees is final. A write that lands in the same cycle
// may be forwarded to a read port (BYPASS). Register 0 may be hardwired to
// zero (ZERO_R0).
//
// Ports:
//   iw_clk, iw_rst        clock (rising edge), asynchronous active-high reset
//   iw_read_addr          NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   ow_read_data          NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   ow_read_ready         per read port: data is final (not pending, or bypassed now)
//   iw_wa_enable/addr/data  write port A (ALU)
//   iw_wb_enable/addr/data  write port B (load)
//   iw_issue_enable/addr  an issued instruction will write iw_issue_addr
//   ow_pending            scoreboard, bit i = register i has an outstanding write
module reggp_sb #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic [NUM_RD*ADDR_W-1:0] iw_read_addr,
    output logic [NUM_RD*DATA_W-1:0] ow_read_data,
    output logic [NUM_RD-1:0]        ow_read_ready,
    input  logic                     iw_wa_enable,
    input  logic [ADDR_W-1:0]        iw_wa_addr,
    input  logic [DATA_W-1:0]        iw_wa_data,
    input  logic                     iw_wb_enable,
    input  logic [ADDR_W-1:0]        iw_wb_addr,
    input  logic [DATA_W-1:0]        iw_wb_data,
    input  logic                     iw_issue_enable,
    input  logic [ADDR_W-1:0]        iw_issue_addr,
    output logic [NUM_REGS-1:0]      ow_pending
);

    localparam bit BYP_EN  = (BYPASS != 0);
    localparam bit ZERO_EN = (ZERO_R0 != 0);

    logic [DATA_W-1:0]        regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]      pending_r;
    logic [NUM_REGS-1:0]      wa_hit_s;
    logic [NUM_REGS-1:0]      wb_hit_s;
    logic [NUM_REGS-1:0]      issue_hit_s;
    logic [NUM_RD*DATA_W-1:0] read_data_s;
    logic [NUM_RD-1:0]        read_ready_s;

    // Per-register write/issue decode. Out-of-range addresses match no register,
    // a hardwired r0 never matches, and nothing matches while reset is held so
    // that neither the array nor the bypass path sees in-flight traffic.
    always_comb begin
        wa_hit_s    = {NUM_REGS{1'b0}};
        wb_hit_s    = {NUM_REGS{1'b0}};
        issue_hit_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!(ZERO_EN && (i == 0)) && !iw_rst) begin
                wa_hit_s[i]    = iw_wa_enable    && (iw_wa_addr    == ADDR_W'(i));
                wb_hit_s[i]    = iw_wb_enable    && (iw_wb_addr    == ADDR_W'(i));
                issue_hit_s[i] = iw_issue_enable && (iw_issue_addr == ADDR_W'(i));
            end else begin
                wa_hit_s[i]    = 1'b0;
                wb_hit_s[i]    = 1'b0;
                issue_hit_s[i] = 1'b0;
            end
        end
    end

    // Register array; port B overrides port A on a shared destination.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_hit_s[i]) begin
                    regs_r[i] <= iw_wb_data;
                end else if (wa_hit_s[i]) begin
                    regs_r[i] <= iw_wa_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Scoreboard: an issue beats a same-cycle write because the newly issued
    // producer is still outstanding after the older one retires.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue_hit_s[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (wa_hit_s[i] || wb_hit_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Read ports: a one-hot scan over the array, so an out-of-range address
    // falls through to data 0 with ready 1.
    always_comb begin
        read_data_s  = {(NUM_RD*DATA_W){1'b0}};
        read_ready_s = {NUM_RD{1'b1}};
        for (int k = 0; k < NUM_RD; k++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (iw_read_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    if (BYP_EN && wb_hit_s[i]) begin
                        read_data_s[k*DATA_W +: DATA_W] = iw_wb_data;
                    end else if (BYP_EN && wa_hit_s[i]) begin
                        read_data_s[k*DATA_W +: DATA_W] = iw_wa_data;
                    end else begin
                        read_data_s[k*DATA_W +: DATA_W] = regs_r[i];
                    end
                    read_ready_s[k] = !pending_r[i] ||
                                      (BYP_EN && (wa_hit_s[i] || wb_hit_s[i]));
                end else begin
                    read_data_s[k*DATA_W +: DATA_W] = read_data_s[k*DATA_W +: DATA_W];
                    read_ready_s[k] = read_ready_s[k];
                end
            end
        end
    end

    assign ow_read_data  = read_data_s;
    assign ow_read_ready = read_ready_s;
    assign ow_pending    = pending_r;

endmodule
